matmul_sched: RTL
=================

# matmul_sched

Sequencing controller for the matrix-multiply datapath. Computes C = A·B, with A of size rows×inner and B of size inner×cols, by driving a single external dot-product/MAC unit one term per cycle. Walks output elements in row-major order and generates operand-storage read indices and first/last term flags. Collects MAC sums into a credit-protected result FIFO and presents each result with its (row, col) coordinate on a valid/ready stream.

## Interface
- DATA_WIDTH, 16, operand and result element width (signed)
- ACC_WIDTH, 37, MAC sum width (signed), nominally 2·DATA_WIDTH+IDX_W
- MAX_DIM, 32, maximum value of any dimension; IDX_W = $clog2(MAX_DIM) (localparam)
- RES_DEPTH, 4, result FIFO depth (≥2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  job request; accepted only in IDLE
- cfg_rows, cfg_inner, cfg_cols  in  IDX_W+1 each  dimensions; sampled on accepted start
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at job completion
- err  out  1  one-cycle pulse on rejected start
- op_valid  out  1  term issued this cycle
- a_row, a_col, b_row, b_col  out  IDX_W each  operand read indices: A(i,k), B(k,j)
- term_first, term_last  out  1 each  qualified by op_valid; k==0 and k==inner-1
- mac_sum_valid  in  1  MAC sum valid; exactly 2 cycles after the op_valid&term_last issue
- mac_sum  in  ACC_WIDTH  dot-product result
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer accept
- res_data  out  DATA_WIDTH  converted result
- res_row, res_col  out  IDX_W each  coordinate of res_data

## Operation
- FSM states are IDLE, RUN and DRAIN.
- IDLE:
  - start with all dims in 1..MAX_DIM: latch dims, clear counters i/j/k, go to RUN.
  - start with any dim equal to 0 or greater than MAX_DIM: pulse err, stay in IDLE.
- RUN:
  - Each cycle issues term (i,j,k) when not stalled. Increment k; on wrap, increment j; on j wrap, increment i.
  - After issuing the term (rows-1, cols-1, inner-1), go to DRAIN.
- Stall rule:
  - A term with term_last=1 issues only if credits > 0.
  - credits = RES_DEPTH − fifo_count − in_flight.
  - in_flight increments on a last-term issue and decrements on mac_sum_valid.
  - Non-last terms never stall.
  - While stalled: op_valid=0 and all indices hold.
- DRAIN: when in_flight==0, FIFO empty and no handshake this cycle, pulse done and go to IDLE.
- Result path:
  - Each mac_sum_valid pushes the converted sum with coordinate (oi, oj).
  - oi/oj are a row-major output counter, independent of the issue counters.
  - Results leave in issue order.
- The credit rule guarantees the FIFO never overflows.
- mac_sum_valid with in_flight==0 is ignored (no push).
- start while busy is ignored: no err, and dims are not resampled.

## Timing
- All outputs reset to 0: busy, done, err, op_valid, indices, flags, res_valid, res_data, res_row, res_col. FSM resets to IDLE, FIFO to empty, counters to 0.
- Accepted start at cycle t:
  - busy=1 and the first op_valid (indices 0,0,0,0; term_first=1) at t+1.
  - Unstalled issue is contiguous: rows·cols·inner cycles.
- Result timing:
  - A sum returned at cycle s is pushed at s; res_valid=1 at s+1.
  - A FIFO pop occurs on res_valid&res_ready.
  - Simultaneous push and pop in the same cycle is legal; count is unchanged.
- done is asserted the cycle after the final result handshake; busy falls in the same cycle as done.
- err is asserted at t+1 for a rejected start at t.
- inner=1: term_first and term_last are both 1 on every term.
- Reset mid-job: immediate abort to reset values. Sums arriving after reset deassertion are ignored (in_flight==0).

## Configuration
- MATMUL_SAT_EN defined: res_data = mac_sum saturated to the signed DATA_WIDTH range.
- MATMUL_SAT_EN undefined: res_data = mac_sum[DATA_WIDTH-1:0], i.e. two's-complement truncation.
- Conversion is applied at FIFO push.

## Test plan
- Reset checks:
  - Assert reset asynchronously mid-cycle -> every output is 0 immediately.
  - After release, start with dims 1,1,1 -> op_valid at t+1 and one result at (0,0).
- 2×3·3×2, res_ready=1, MAC model returns 2 cycles after each last term:
  - 12 contiguous op_valid cycles.
  - Results in order (0,0), (0,1), (1,0), (1,1).
  - done is a 1-cycle pulse the cycle after the (1,1) handshake.
- rows=cols=4, inner=1, res_ready=0:
  - Exactly RES_DEPTH=4 terms issue, then op_valid stays 0.
  - After raising res_ready, all 16 results arrive row-major with no loss.
- Invalid configuration:
  - start with cfg_inner=0 -> err pulse at t+1, busy stays 0.
  - start with cfg_cols=33 -> same response.
- Conversion, single-term job with mac_sum=40000:
  - MATMUL_SAT_EN defined -> res_data=32767.
  - MATMUL_SAT_EN undefined -> res_data=−25536.
  - mac_sum=−40000 with MATMUL_SAT_EN -> −32768.
- Reset during RUN (3,3,3 job at its 10th term):
  - All outputs 0; late mac_sum_valid pulses produce no res_valid.
  - A new 2,2,2 job then completes correctly.

Source files
------------

// File: rtl/matmul_sched.sv
// Matrix-multiply sequencer: walks C = A*B terms for an external MAC and collects sums into a credit-protected result FIFO.
// Optional MATMUL_SAT_EN: saturate results to the signed DATA_WIDTH range instead of truncating.
module matmul_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 37,
  parameter int MAX_DIM    = 32,
  parameter int RES_DEPTH  = 4,
  localparam int IDX_W     = $clog2(MAX_DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDX_W:0]        cfg_rows,
  input  logic [IDX_W:0]        cfg_inner,
  input  logic [IDX_W:0]        cfg_cols,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  op_valid,
  output logic [IDX_W-1:0]      a_row,
  output logic [IDX_W-1:0]      a_col,
  output logic [IDX_W-1:0]      b_row,
  output logic [IDX_W-1:0]      b_col,
  output logic                  term_first,
  output logic                  term_last,
  input  logic                  mac_sum_valid,
  input  logic [ACC_WIDTH-1:0]  mac_sum,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [IDX_W-1:0]      res_row,
  output logic [IDX_W-1:0]      res_col
);

  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam logic [IDX_W:0] DIM_MAX  = (IDX_W + 1)'(MAX_DIM);
  localparam logic [IDX_W:0] DIM_ONE  = (IDX_W + 1)'(1);
  localparam logic [CW:0]    DEPTH_C  = (CW + 1)'(RES_DEPTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]  PTR_LAST = PW'(RES_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_nx;
  logic [IDX_W:0]       rows_r, inner_r, cols_r;
  logic [IDX_W-1:0]     i, j, k, oi, oj;
  logic [CW-1:0]        in_flight, count;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem_data [RES_DEPTH];
  logic [IDX_W-1:0]     mem_row  [RES_DEPTH];
  logic [IDX_W-1:0]     mem_col  [RES_DEPTH];
  logic                 err_r;
  logic [DATA_WIDTH-1:0] conv;

  logic dims_ok, accept, issue, stall, push, pop, drain_done;
  logic k_last, j_last, i_last, oj_last;
  logic [CW:0] pending;

  assign dims_ok = (cfg_rows  != '0) && (cfg_rows  <= DIM_MAX) &&
                   (cfg_inner != '0) && (cfg_inner <= DIM_MAX) &&
                   (cfg_cols  != '0) && (cfg_cols  <= DIM_MAX);
  assign k_last  = ({1'b0, k}  == inner_r - DIM_ONE);
  assign j_last  = ({1'b0, j}  == cols_r  - DIM_ONE);
  assign i_last  = ({1'b0, i}  == rows_r  - DIM_ONE);
  assign oj_last = ({1'b0, oj} == cols_r  - DIM_ONE);

  // Sums already in the MAC pipeline reserve FIFO slots, so a last term waits for a free slot.
  assign pending    = {1'b0, count} + {1'b0, in_flight};
  assign stall      = k_last && (pending >= DEPTH_C);
  assign accept     = (state == IDLE) && start && dims_ok;
  assign issue      = (state == RUN) && !stall;
  assign push       = mac_sum_valid && (in_flight != '0);
  assign res_valid  = (count != '0);
  assign pop        = res_valid && res_ready;
  assign drain_done = (state == DRAIN) && (in_flight == '0) && (count == '0) && !pop;

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
  always_comb begin
    conv = mac_sum[DATA_WIDTH-1:0];
    if ($signed(mac_sum) > SAT_HI)      conv = SAT_HI[DATA_WIDTH-1:0];
    else if ($signed(mac_sum) < SAT_LO) conv = SAT_LO[DATA_WIDTH-1:0];
  end
`else
  logic unused_hi;
  assign conv      = mac_sum[DATA_WIDTH-1:0];
  assign unused_hi = ^mac_sum[ACC_WIDTH-1:DATA_WIDTH];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (issue && k_last && j_last && i_last) state_nx = DRAIN;
      DRAIN:   if (drain_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    op_valid   = issue;
    busy       = (state == RUN) || ((state == DRAIN) && !drain_done);
    done       = drain_done;
    err        = err_r;
    term_first = issue && (k == '0);
    term_last  = issue && k_last;
    a_row      = i;
    a_col      = k;
    b_row      = k;
    b_col      = j;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_r <= '0; inner_r <= '0; cols_r <= '0;
      i <= '0; j <= '0; k <= '0;
      err_r <= 1'b0;
    end else begin
      err_r <= (state == IDLE) && start && !dims_ok;
      if (accept) begin
        rows_r <= cfg_rows; inner_r <= cfg_inner; cols_r <= cfg_cols;
        i <= '0; j <= '0; k <= '0;
      end else if (issue) begin
        if (!k_last) k <= k + 1'b1;
        else begin
          k <= '0;
          if (!j_last) j <= j + 1'b1;
          else begin
            j <= '0;
            i <= i + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight <= '0; count <= '0;
      wr_ptr <= '0; rd_ptr <= '0;
      oi <= '0; oj <= '0;
    end else begin
      case ({issue && k_last, push})
        2'b10:   in_flight <= in_flight + CNT_ONE;
        2'b01:   in_flight <= in_flight - CNT_ONE;
        default: ;
      endcase
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      if (accept) begin
        oi <= '0; oj <= '0;
      end else if (push) begin
        if (oj_last) begin
          oj <= '0;
          oi <= oi + 1'b1;
        end else oj <= oj + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= conv;
      mem_row[wr_ptr]  <= oi;
      mem_col[wr_ptr]  <= oj;
    end
  end

  assign res_data = res_valid ? mem_data[rd_ptr] : '0;
  assign res_row  = res_valid ? mem_row[rd_ptr]  : '0;
  assign res_col  = res_valid ? mem_col[rd_ptr]  : '0;

endmodule
